// File: rtl/pi_pkg.sv
// pi_pkg: select encodings shared by the router select logic and the output buffers.
package pi_pkg;
  localparam logic [2:0] SEL_IN0 = 3'd0;
  localparam logic [2:0] SEL_IN1 = 3'd1;
  localparam logic [2:0] SEL_IN2 = 3'd2;
  function automatic logic sel_legal(input logic [2:0] s);
    return s <= SEL_IN2;
  endfunction
endpackage

// File: rtl/pi_out_buf_if.sv
// pi_out_buf_if: router-grant side and downstream side of one output buffer.
interface pi_out_buf_if #(parameter int D_W = 32, parameter int A_W = 4);
  logic           ce;
  logic           i_v;
  logic [2:0]     i_sel;
  logic [A_W-1:0] in0_addr, in1_addr, in2_addr;
  logic [D_W-1:0] in0_data, in1_data, in2_data;
  logic           i_bp;
  logic           o_v;
  logic [A_W-1:0] o_addr;
  logic [D_W-1:0] o_data;
  logic           o_bp;
  logic           err;
  modport master(
    output ce, i_v, i_sel, in0_addr, in1_addr, in2_addr, in0_data, in1_data, in2_data, o_bp,
    input  i_bp, o_v, o_addr, o_data, err
  );
  modport slave(
    input  ce, i_v, i_sel, in0_addr, in1_addr, in2_addr, in0_data, in1_data, in2_data, o_bp,
    output i_bp, o_v, o_addr, o_data, err
  );
endinterface

// File: rtl/pi_skid2.sv
// pi_skid2: two-entry FIFO with 1-bit wrapping pointers; head always visible on dout.
module pi_skid2 #(parameter int W = 36) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wptr, rptr;
  logic [1:0]   count;
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout  = mem[rptr];
  assign full  = count == 2'd2;
  assign empty = count == 2'd0;
endmodule

// File: rtl/pi_out_buf.sv
// pi_out_buf: per-output-port 3:1 select, illegal-select flag and ce gating around a 2-entry FIFO.
module pi_out_buf import pi_pkg::*; #(
  parameter int D_W   = 32,
  parameter int A_W   = 4,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  pi_out_buf_if.slave  bus
);
  localparam int W = A_W + D_W;
  if (DEPTH != 2) begin : g_depth
    $error("pi_out_buf supports DEPTH=2 only");
  end
  logic [W-1:0] sel_word, head;
  logic         req, legal, push, pop, full, empty, err_q;
  always_comb begin
    sel_word = (bus.i_sel == SEL_IN0) ? {bus.in0_addr, bus.in0_data} :
               (bus.i_sel == SEL_IN1) ? {bus.in1_addr, bus.in1_data} :
                                        {bus.in2_addr, bus.in2_data};
  end
  assign legal = sel_legal(bus.i_sel);
  // i_bp depends only on registered fullness and ce, so req never loops back through it
  assign req   = bus.ce & bus.i_v & ~bus.i_bp;
  assign push  = req & legal;
  assign pop   = bus.o_v & ~bus.o_bp;
  pi_skid2 #(.W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sel_word),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (req & ~legal) err_q <= 1'b1;
  end
  assign bus.i_bp                 = full | ~bus.ce;
  assign bus.o_v                  = ~empty & bus.ce;
  assign {bus.o_addr, bus.o_data} = head;
  assign bus.err                  = err_q;
endmodule

// File: doc/pi_out_buf.md
PI_OUT_BUF -- requirements
Module: pi_out_buf

Interface
REQ-001 Parameter D_W, default 32, payload data width in bits.
REQ-002 Parameter A_W, default 4, address width in bits; the address travels with the data unmodified.
REQ-003 Parameter DEPTH, default 2, buffer entries; only the value 2 is supported.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ce  in  1  clock enable.
- i_v  in  1  router grant valid for this output port.
- i_sel  in  3  router mux select: 0=in0, 1=in1, 2=in2; 3..7 are illegal.
- in0_addr, in1_addr, in2_addr  in  A_W each  candidate addresses.
- in0_data, in1_data, in2_data  in  D_W each  candidate data.
- i_bp  out  1  backpressure to the router's output-bp input.
- o_v  out  1  output valid toward the next switch or client.
- o_addr  out  A_W  output address.
- o_data  out  D_W  output data.
- o_bp  in  1  downstream backpressure.
- err  out  1  sticky illegal-select flag.

Function
REQ-005 Push SHALL occur when ce=1, i_v=1, i_bp=0 and i_sel<=2.
- The pushed entry is the {addr, data} of the selected candidate.
REQ-006 Pop SHALL occur when ce=1, o_v=1 and o_bp=0.
REQ-007 i_bp SHALL equal (count==2) OR (ce==0).
- The count term comes from a register only.
- i_bp has no combinational path from i_v, i_sel or o_bp.
REQ-008 o_v SHALL equal (count!=0) AND ce.
- o_addr and o_data SHALL always present the head entry.
REQ-009 Latency: a word pushed in cycle N SHALL appear on o_v/o_data no earlier than cycle N+1; there is no combinational bypass.
REQ-010 Ordering SHALL be strict FIFO.
- No loss, no duplication.
- Head data SHALL hold stable while o_v=1 and o_bp=1.
REQ-011 count (0..2) update rules:
- push only: count+1.
- pop only: count-1.
- push and pop together (legal only at count 1): count unchanged; the new entry becomes head on the next cycle.
REQ-012 Full (count==2): i_bp=1, so no push can occur.
- A pop in that cycle SHALL make count 1 and deassert i_bp in the next cycle.
REQ-013 Empty (count==0): o_v=0; a pop cannot occur.
REQ-014 Storage SHALL be two entries addressed by 1-bit write and read pointers that wrap 1->0.
REQ-015 If i_v=1, ce=1, i_bp=0 and i_sel>2:
- no push occurs;
- err SHALL set to 1 and hold until reset.
REQ-016 With ce=0, all state SHALL hold: count, pointers, storage and err.
REQ-017 Control state (count, pointers, err) SHALL be 5 flops; storage SHALL be 2*(A_W+D_W) flops.

Reset
REQ-018 With rst=1 at a rising edge, the block SHALL set count=0, wptr=0, rptr=0 and err=0.
REQ-019 During and after reset: o_v=0, i_bp=0 (with ce=1), and o_addr/o_data equal zero.
- Storage entries SHALL also be cleared.
REQ-020 Reset asserted mid-operation SHALL discard all buffered entries.
- No push or pop SHALL be performed in a reset cycle, regardless of i_v or o_bp.

Structure
REQ-021 Shared package pi_pkg SHALL hold the select-encoding constants SEL_IN0=0, SEL_IN1=1, SEL_IN2=2.
- The router select generation and this block SHALL use the same constants.
REQ-022 One sub-module, pi_skid2, SHALL implement the 2-entry FIFO (storage, pointers, count, full/empty).
- pi_out_buf SHALL contain only the 3:1 select mux, the illegal-select detection and the ce gating.
REQ-023 One pi_out_buf SHALL be instantiated per router output port, i.e. four per switch.
- Each instance's i_bp drives that router's corresponding output-bp input.

Verification
REQ-024 Single word: push sel=1 with in1_data=0xA5A5A5A5, in1_addr=5, o_bp=0 in cycle 0 -> cycle 1 shows o_v=1, o_data=0xA5A5A5A5, o_addr=5; cycle 2 shows o_v=0.
REQ-025 Fill and stall: o_bp=1, push 0x11 (sel 0) then 0x22 (sel 2) -> count=2 and i_bp=1 from cycle 2; o_data holds 0x11; release o_bp -> 0x11 then 0x22 in order; i_bp=0 one cycle after the first pop.
REQ-026 Streaming: count=1, push every cycle, o_bp=0 -> continuous o_v for 10 words in order, i_bp never asserts, count stays 1.
REQ-027 Illegal select: i_v=1, i_sel=5 -> no o_v in the following cycle, err=1 and held; rst -> err=0.
REQ-028 Reset mid-operation: count=2, assert rst for one cycle -> o_v=0 and i_bp=0 on the next cycle; the previously buffered words never appear.
REQ-029 ce gating: count=1, ce=0 for 3 cycles with i_v=1 -> o_v=0 and i_bp=1 throughout; the state is preserved and the word emerges once ce=1.
